// File: rtl/display_scheduler.sv
// display_scheduler
// Sequencer for the shared 7-bit scoreboard display path. Drives the two
// select lines of the display multiplexer: sel_team alternates Team 1 /
// Team 2 at scan rate during the score phase, and sel_timer switches between
// the score phase and the stopwatch phase. Blanks the display while disabled
// and lets force_timer pin the stopwatch phase.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   enable      in   display on; low forces IDLE (blank) immediately at the edge
//   force_timer in   enter/hold stopwatch phase, sampled on scan ticks only
//   sel_timer   out  1 = stopwatch, 0 = scores
//   sel_team    out  0 = Team 1, 1 = Team 2 (held 0 in stopwatch phase)
//   blank       out  1 = display dark
//   scan_tick   out  one-cycle pulse per scan tick
//   phase_done  out  one-cycle pulse on every SCORE<->TIMER change
//   state_dbg   out  current FSM state (IDLE=0, SCORE=1, TIMER=2)
//
// All outputs are registered. The sequencer has no handshake; every input is
// simply sampled on the rising clock edge.
module display_scheduler #(
  parameter int CLK_DIV     = 416667,
  parameter int SCORE_TICKS = 240,
  parameter int TIMER_TICKS = 240
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       force_timer,
  output logic       sel_timer,
  output logic       sel_team,
  output logic       blank,
  output logic       scan_tick,
  output logic       phase_done,
  output logic [1:0] state_dbg
);

  localparam int PH_MAX = (SCORE_TICKS > TIMER_TICKS) ? SCORE_TICKS : TIMER_TICKS;
  localparam int DW     = $clog2(CLK_DIV);
  localparam int PW     = $clog2(PH_MAX);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] SCORE_LAST = PW'(SCORE_TICKS - 1);
  localparam logic [PW-1:0] TIMER_LAST = PW'(TIMER_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCORE = 2'd1,
    TIMER = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_cnt_n;
  logic [PW-1:0] ph_cnt, ph_cnt_n;
  logic          sel_timer_n, sel_team_n, blank_n, scan_tick_n, phase_done_n;

  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      ph_cnt     <= '0;
      sel_timer  <= 1'b0;
      sel_team   <= 1'b0;
      blank      <= 1'b1;
      scan_tick  <= 1'b0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_n;
      div_cnt    <= div_cnt_n;
      ph_cnt     <= ph_cnt_n;
      sel_timer  <= sel_timer_n;
      sel_team   <= sel_team_n;
      blank      <= blank_n;
      scan_tick  <= scan_tick_n;
      phase_done <= phase_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    div_cnt_n    = div_cnt;
    ph_cnt_n     = ph_cnt;
    sel_timer_n  = sel_timer;
    sel_team_n   = sel_team;
    blank_n      = blank;
    scan_tick_n  = 1'b0;
    phase_done_n = 1'b0;

    if (!enable) begin
      // Disable wins over everything, including mid-phase.
      state_n     = IDLE;
      div_cnt_n   = '0;
      ph_cnt_n    = '0;
      sel_timer_n = 1'b0;
      sel_team_n  = 1'b0;
      blank_n     = 1'b1;
    end else if (state == IDLE) begin
      // Always restart with Team 1 and fresh counters.
      state_n     = SCORE;
      div_cnt_n   = '0;
      ph_cnt_n    = '0;
      sel_timer_n = 1'b0;
      sel_team_n  = 1'b0;
      blank_n     = 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt_n   = '0;
      scan_tick_n = 1'b1;
      if (state == SCORE) begin
        if (ph_cnt == SCORE_LAST || force_timer) begin
          state_n      = TIMER;
          ph_cnt_n     = '0;
          sel_timer_n  = 1'b1;
          sel_team_n   = 1'b0;
          phase_done_n = 1'b1;
        end else begin
          ph_cnt_n   = ph_cnt + PW'(1);
          sel_team_n = ~sel_team;
        end
      end else begin
        // TIMER: force restarts the phase count so the phase persists.
        if (force_timer) begin
          ph_cnt_n = '0;
        end else if (ph_cnt == TIMER_LAST) begin
          state_n      = SCORE;
          ph_cnt_n     = '0;
          sel_timer_n  = 1'b0;
          sel_team_n   = 1'b0;
          phase_done_n = 1'b1;
        end else begin
          ph_cnt_n = ph_cnt + PW'(1);
        end
      end
    end else begin
      div_cnt_n = div_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       force_timer;
  logic       sel_timer;
  logic       sel_team;
  logic       blank;
  logic       scan_tick;
  logic       phase_done;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int n      = 0;  // cycle index: the interval following edge En

  display_scheduler #(
    .CLK_DIV    (4),
    .SCORE_TICKS(4),
    .TIMER_TICKS(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .force_timer(force_timer),
    .sel_timer  (sel_timer),
    .sel_team   (sel_team),
    .blank      (blank),
    .scan_tick  (scan_tick),
    .phase_done (phase_done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // advance one edge, sample 1 time unit later
  task automatic step();
    @(posedge clock);
    #1;
    n++;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".state"},      state_dbg,  0);
    check_eq({tag, ".blank"},      blank,      1);
    check_eq({tag, ".sel_timer"},  sel_timer,  0);
    check_eq({tag, ".sel_team"},   sel_team,   0);
    check_eq({tag, ".scan_tick"},  scan_tick,  0);
    check_eq({tag, ".phase_done"}, phase_done, 0);
  endtask

  // Hand-derived free-running pattern for CLK_DIV=4, SCORE=4, TIMER=2:
  // 24-cycle period, score cycles 0-15 (team flips every 4), timer 16-23.
  task automatic check_normal(input string tag);
    int p;
    p = n % 24;
    check_eq({tag, ".blank"},      blank,      0);
    check_eq({tag, ".sel_timer"},  sel_timer,  (p >= 16) ? 1 : 0);
    check_eq({tag, ".sel_team"},   sel_team,   (p < 16) ? (p / 4) % 2 : 0);
    check_eq({tag, ".scan_tick"},  scan_tick,  (n > 0 && p % 4 == 0) ? 1 : 0);
    check_eq({tag, ".phase_done"}, phase_done, (p == 16 || (p == 0 && n > 0)) ? 1 : 0);
    check_eq({tag, ".state"},      state_dbg,  (p >= 16) ? 2 : 1);
  endtask

  // pass through IDLE for one edge then start a fresh run at E0
  task automatic restart();
    enable = 1'b0;
    step();
    check_idle("restart_idle");
    enable = 1'b1;
    step();
    n = 0;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    force_timer = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_idle("reset");

    // release reset with enable high: SCORE on the very next edge
    enable = 1'b1;
    reset  = 1'b0;
    step();
    n = 0;
    check_eq("rel.state", state_dbg, 1);
    check_eq("rel.blank", blank, 0);

    // normal cycle over two full periods plus a bit
    for (int i = 1; i <= 52; i++) begin
      step();
      check_normal("normal");
    end

    // async reset mid-clock at cycle 52 (sel_team=1, scan_tick=1 here)
    check_eq("pre_rst.sel_team", sel_team, 1);
    #3;
    reset = 1'b1;
    #1;
    check_idle("async_rst");
    #2;
    reset = 1'b0;
    step();
    n = 0;
    check_eq("rst2.blank", blank, 0);
    check_eq("rst2.state", state_dbg, 1);

    // force raised at cycle 5 -> TIMER at E8, held through E40, dropped at 41
    restart();
    for (int i = 1; i <= 48; i++) begin
      step();
      if (n == 5) force_timer = 1'b1;
      if (n == 41) force_timer = 1'b0;
      if (n < 8) begin
        check_eq("force.sel_timer_pre", sel_timer, 0);
      end else if (n < 48) begin
        check_eq("force.sel_timer_held", sel_timer, 1);
        check_eq("force.sel_team_held", sel_team, 0);
        check_eq("force.phase_done", phase_done, (n == 8) ? 1 : 0);
      end else begin
        check_eq("force.sel_timer_back", sel_timer, 0);
        check_eq("force.phase_done_back", phase_done, 1);
        check_eq("force.sel_team_back", sel_team, 0);
      end
    end

    // force pulse during cycles 9-10 only: no effect
    restart();
    for (int i = 1; i <= 24; i++) begin
      step();
      if (n == 9) force_timer = 1'b1;
      if (n == 11) force_timer = 1'b0;
      check_normal("pulse");
    end

    // disable mid-phase at cycle 18, then full restart
    restart();
    for (int i = 1; i <= 18; i++) begin
      step();
      check_normal("dis_pre");
    end
    enable = 1'b0;
    step();
    check_idle("dis_mid");
    enable = 1'b1;
    step();
    n = 0;
    check_normal("dis_restart");
    for (int i = 1; i <= 17; i++) begin
      step();
      check_normal("dis_restart");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
Sequencer for the scoreboard's shared 7-bit display path. It generates the two select lines of the display multiplexer: sel_team alternates Team 1 / Team 2 scores at scan rate, and sel_timer switches between the score phase and the stopwatch phase. It also provides blanking while disabled and a force input that pins the stopwatch phase. It sits between the system clock and the display mux, replacing the free-running 60 Hz and 2 s clocks.

Parameters:
- CLK_DIV, 416667, clock cycles per scan tick (>=2); 50 MHz / 416667 ≈ 120 Hz tick, giving a 60 Hz team alternation.
- SCORE_TICKS, 240, scan ticks spent in the score phase (even, >=2).
- TIMER_TICKS, 240, scan ticks spent in the stopwatch phase (>=1).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  display on; low forces the idle/blank state.
- force_timer  input  1  hold or enter the stopwatch phase at the next scan tick.
- sel_timer  output  1  mux select; 1 = stopwatch, 0 = scores.
- sel_team  output  1  mux select in score phase; 0 = Team 1, 1 = Team 2.
- blank  output  1  1 = display must be dark.
- scan_tick  output  1  one-cycle pulse per scan tick.
- phase_done  output  1  one-cycle pulse on each SCORE<->TIMER change.

Behaviour:
- All outputs are registered.
- Reset (async) and IDLE values: state IDLE, div_cnt=0, ph_cnt=0, sel_timer=0, sel_team=0, blank=1, scan_tick=0, phase_done=0.
- Counter widths: div_cnt is $clog2(CLK_DIV) bits; ph_cnt is $clog2(max(SCORE_TICKS,TIMER_TICKS)) bits. Both wrap to 0 by explicit compare, never by overflow.
- Priority: enable=0 on any edge → IDLE with the reset values above. This overrides everything else, including mid-phase.
- IDLE → SCORE on an edge with enable=1. That edge sets div_cnt=0, ph_cnt=0, sel_timer=0, sel_team=0, blank=0.
- Tick edge: an edge where state≠IDLE and div_cnt==CLK_DIV-1.
  - On a tick edge: div_cnt←0, scan_tick←1.
  - On any other edge: div_cnt increments and scan_tick←0.
- SCORE, tick edge:
  - If ph_cnt==SCORE_TICKS-1 or force_timer=1: go to TIMER; ph_cnt←0, sel_timer←1, sel_team←0, phase_done←1.
  - Otherwise: ph_cnt++, sel_team toggles.
- TIMER, tick edge:
  - If force_timer=1: stay in TIMER, ph_cnt←0.
  - Else if ph_cnt==TIMER_TICKS-1: go to SCORE; ph_cnt←0, sel_timer←0, sel_team←0, phase_done←1.
  - Otherwise: ph_cnt++.
- phase_done is 0 on every edge that is not a transition edge.
- force_timer is sampled only on tick edges; pulses between ticks are ignored.
- In TIMER, sel_team is held at 0.
- Latencies:
  - First scan_tick: CLK_DIV cycles after the IDLE→SCORE edge.
  - SCORE phase: SCORE_TICKS·CLK_DIV cycles.
  - TIMER phase: TIMER_TICKS·CLK_DIV cycles.
- Because SCORE_TICKS is even, every score phase shows each team for an equal number of ticks.
- Re-asserting enable after IDLE always restarts at SCORE with Team 1 and fresh counters.

Test Plan (CLK_DIV=4, SCORE_TICKS=4, TIMER_TICKS=2 unless noted):
- Reset: assert reset mid-clock with enable=1 → all outputs go to reset values immediately, without waiting for an edge. Release reset → SCORE is entered on the next edge and blank falls.
- Normal cycle: enable=1 from edge E0.
  - sel_team = 0 for cycles 0-3, 1 for 4-7, 0 for 8-11, 1 for 12-15.
  - scan_tick is high after E4, E8, E12 and E16.
  - At E16: sel_timer=1, phase_done=1.
  - At E24: back to SCORE with sel_team=0 and phase_done=1. Pattern then repeats with a 24-cycle period.
- Force: raise force_timer at cycle 5 → TIMER is entered at E8 (next tick), not E5. Hold force_timer through E40 → sel_timer stays 1. Drop it at cycle 41 → return to SCORE at E48.
- Force pulse missed: force_timer is high only during cycles 9-10 → no effect; TIMER is still entered at E16.
- Disable mid-phase: drop enable at cycle 18 (in TIMER) → at E19 blank=1 and sel_timer=0. Re-enable → restart in SCORE with a full 16-cycle score phase.
- Default parameters: 50 MHz simulation.
  - sel_team period is 833334 cycles.
  - Score phase is 240·416667 cycles (≈2.0 s), followed by an equal timer phase.
